// File: rtl/instruction_fetch.sv
// instruction_fetch: PC generation and IF/ID pipeline register for the 32-bit single-issue core.
//
// The block sits in front of a combinational instruction memory. It presents the PC on
// imem_addr_o and registers the returned word, together with its PC and PC+4, toward decode.
//
// Ports:
//   clk                - rising-edge clock
//   rst_n              - synchronous, active-low reset
//   stall_i            - hazard unit request to hold PC and IF/ID
//   redirect_i         - taken branch/jump from execute; wins over stall_i
//   redirect_target_i  - new PC when redirect_i is high (low two bits are dropped)
//   imem_addr_o        - fetch address, always the PC register
//   imem_instr_i       - instruction word returned combinationally for imem_addr_o
//   if_id_pc_o         - PC of the registered instruction
//   if_id_pc4_o        - if_id_pc_o + 4
//   if_id_instr_o      - registered instruction, NOP_INSTR for a bubble
//   if_id_valid_o      - registered instruction is real
//   fetch_fault_o      - sticky: a fetch was attempted outside the instruction memory
//   misalign_fault_o   - sticky: a redirect target was not word aligned
module instruction_fetch #(
  parameter int unsigned          DATA_WIDTH    = 32,
  parameter int unsigned          ADDRESS_WIDTH = 32,
  parameter int unsigned          MEM_SIZE      = 256,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC  = '0,
  parameter logic [DATA_WIDTH-1:0]    NOP_INSTR = 32'h0000_0013
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     stall_i,
  input  logic                     redirect_i,
  input  logic [ADDRESS_WIDTH-1:0] redirect_target_i,
  output logic [ADDRESS_WIDTH-1:0] imem_addr_o,
  input  logic [DATA_WIDTH-1:0]    imem_instr_i,
  output logic [ADDRESS_WIDTH-1:0] if_id_pc_o,
  output logic [ADDRESS_WIDTH-1:0] if_id_pc4_o,
  output logic [DATA_WIDTH-1:0]    if_id_instr_o,
  output logic                     if_id_valid_o,
  output logic                     fetch_fault_o,
  output logic                     misalign_fault_o
);

  // Memory size in bytes, one bit wider than an address so a memory covering the whole
  // address space does not wrap to zero.
  localparam logic [ADDRESS_WIDTH:0] MemWords = (ADDRESS_WIDTH+1)'(MEM_SIZE);
  localparam logic [ADDRESS_WIDTH:0] MemBytes = MemWords << 2;

  localparam logic [ADDRESS_WIDTH-1:0] PcStep = ADDRESS_WIDTH'(4);

  logic [ADDRESS_WIDTH-1:0] pc_d, pc_q;
  logic [ADDRESS_WIDTH-1:0] if_id_pc_d, if_id_pc_q;
  logic [ADDRESS_WIDTH-1:0] if_id_pc4_d, if_id_pc4_q;
  logic [DATA_WIDTH-1:0]    if_id_instr_d, if_id_instr_q;
  logic                     if_id_valid_d, if_id_valid_q;
  logic                     fetch_fault_d, fetch_fault_q;
  logic                     misalign_fault_d, misalign_fault_q;

  logic [ADDRESS_WIDTH-1:0] pc_plus4;
  logic                     pc_in_range;

  // Wraps silently modulo 2^ADDRESS_WIDTH.
  assign pc_plus4    = pc_q + PcStep;
  // Compare on the full byte address so index aliasing past the end is never forwarded.
  assign pc_in_range = {1'b0, pc_q} < MemBytes;

  always_comb begin
    pc_d             = pc_q;
    if_id_pc_d       = if_id_pc_q;
    if_id_pc4_d      = if_id_pc4_q;
    if_id_instr_d    = if_id_instr_q;
    if_id_valid_d    = if_id_valid_q;
    fetch_fault_d    = fetch_fault_q;
    misalign_fault_d = misalign_fault_q;

    if (redirect_i) begin
      // Squash the word fetched this cycle; pc/pc4 fields of the bubble keep old values.
      pc_d          = {redirect_target_i[ADDRESS_WIDTH-1:2], 2'b00};
      if_id_instr_d = NOP_INSTR;
      if_id_valid_d = 1'b0;
      if (redirect_target_i[1:0] != 2'b00) begin
        misalign_fault_d = 1'b1;
      end
    end else if (!stall_i) begin
      pc_d        = pc_plus4;
      if_id_pc_d  = pc_q;
      if_id_pc4_d = pc_plus4;
      if (pc_in_range) begin
        if_id_instr_d = imem_instr_i;
        if_id_valid_d = 1'b1;
      end else begin
        if_id_instr_d = NOP_INSTR;
        if_id_valid_d = 1'b0;
        fetch_fault_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q             <= RESET_PC;
      if_id_pc_q       <= '0;
      if_id_pc4_q      <= '0;
      if_id_instr_q    <= NOP_INSTR;
      if_id_valid_q    <= 1'b0;
      fetch_fault_q    <= 1'b0;
      misalign_fault_q <= 1'b0;
    end else begin
      pc_q             <= pc_d;
      if_id_pc_q       <= if_id_pc_d;
      if_id_pc4_q      <= if_id_pc4_d;
      if_id_instr_q    <= if_id_instr_d;
      if_id_valid_q    <= if_id_valid_d;
      fetch_fault_q    <= fetch_fault_d;
      misalign_fault_q <= misalign_fault_d;
    end
  end

  assign imem_addr_o      = pc_q;
  assign if_id_pc_o       = if_id_pc_q;
  assign if_id_pc4_o      = if_id_pc4_q;
  assign if_id_instr_o    = if_id_instr_q;
  assign if_id_valid_o    = if_id_valid_q;
  assign fetch_fault_o    = fetch_fault_q;
  assign misalign_fault_o = misalign_fault_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with default parameters (MEM_SIZE = 256 words).
// The instruction memory model returns "addi x(i+1), x0, 5*(i+1)" for word index i,
// indexed by address bits [9:2] so that fetches past the end alias to low words.
module tb_instruction_fetch;

  localparam logic [31:0] Nop = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_target_i;
  logic [31:0] imem_addr_o;
  logic [31:0] imem_instr_i;
  logic [31:0] if_id_pc_o;
  logic [31:0] if_id_pc4_o;
  logic [31:0] if_id_instr_o;
  logic        if_id_valid_o;
  logic        fetch_fault_o;
  logic        misalign_fault_o;

  int unsigned passed;
  int unsigned total;

  instruction_fetch dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .stall_i          (stall_i),
    .redirect_i       (redirect_i),
    .redirect_target_i(redirect_target_i),
    .imem_addr_o      (imem_addr_o),
    .imem_instr_i     (imem_instr_i),
    .if_id_pc_o       (if_id_pc_o),
    .if_id_pc4_o      (if_id_pc4_o),
    .if_id_instr_o    (if_id_instr_o),
    .if_id_valid_o    (if_id_valid_o),
    .fetch_fault_o    (fetch_fault_o),
    .misalign_fault_o (misalign_fault_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] word_at(input logic [7:0] idx);
    logic [11:0] imm;
    logic [4:0]  rd;
    imm = 12'(5 * (int'(idx) + 1));
    rd  = 5'(int'(idx) + 1);
    return {imm, 5'd0, 3'd0, rd, 7'h13};
  endfunction

  always_comb imem_instr_i = word_at(imem_addr_o[9:2]);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic check_ifid(input string tag, input logic [31:0] pc, input logic [31:0] pc4,
                            input logic [31:0] instr, input logic valid);
    check({tag, " if_id_pc"}, if_id_pc_o, pc);
    check({tag, " if_id_pc4"}, if_id_pc4_o, pc4);
    check({tag, " if_id_instr"}, if_id_instr_o, instr);
    check({tag, " if_id_valid"}, 32'(if_id_valid_o), 32'(valid));
  endtask

  initial begin
    passed            = 0;
    total             = 0;
    rst_n             = 1'b0;
    stall_i           = 1'b0;
    redirect_i        = 1'b0;
    redirect_target_i = 32'h0;

    // Reset state.
    step();
    check("reset pc", imem_addr_o, 32'h0);
    check_ifid("reset", 32'h0, 32'h0, Nop, 1'b0);
    check("reset ffault", 32'(fetch_fault_o), 32'h0);
    check("reset mfault", 32'(misalign_fault_o), 32'h0);

    // Free run: first word appears one edge after pc 0 was presented.
    rst_n = 1'b1;
    step();
    check("run1 pc", imem_addr_o, 32'h4);
    check_ifid("run1", 32'h0, 32'h4, 32'h0050_0093, 1'b1);
    step();
    check("run2 pc", imem_addr_o, 32'h8);
    check_ifid("run2", 32'h4, 32'h8, 32'h00A0_0113, 1'b1);

    // Stall three cycles at pc 8.
    stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall pc", imem_addr_o, 32'h8);
      check_ifid("stall", 32'h4, 32'h8, 32'h00A0_0113, 1'b1);
    end
    stall_i = 1'b0;
    step();
    check("unstall pc", imem_addr_o, 32'hC);
    check_ifid("unstall", 32'h8, 32'hC, word_at(8'd2), 1'b1);
    step();
    check("run3 pc", imem_addr_o, 32'h10);
    check_ifid("run3", 32'hC, 32'h10, word_at(8'd3), 1'b1);

    // Redirect wins over stall; one bubble, old pc fields kept.
    stall_i           = 1'b1;
    redirect_i        = 1'b1;
    redirect_target_i = 32'h40;
    step();
    check("redir pc", imem_addr_o, 32'h40);
    check_ifid("redir", 32'hC, 32'h10, Nop, 1'b0);
    stall_i    = 1'b0;
    redirect_i = 1'b0;
    step();
    check("redir next pc", imem_addr_o, 32'h44);
    check_ifid("redir next", 32'h40, 32'h44, word_at(8'd16), 1'b1);
    check("aligned mfault", 32'(misalign_fault_o), 32'h0);

    // Misaligned target: aligned pc, sticky fault.
    redirect_i        = 1'b1;
    redirect_target_i = 32'h22;
    step();
    check("misalign pc", imem_addr_o, 32'h20);
    check("misalign flag", 32'(misalign_fault_o), 32'h1);
    redirect_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      check("misalign sticky", 32'(misalign_fault_o), 32'h1);
    end
    check("misalign run pc", imem_addr_o, 32'h48);
    check("misalign ffault", 32'(fetch_fault_o), 32'h0);
    rst_n = 1'b0;
    step();
    check("mclr flag", 32'(misalign_fault_o), 32'h0);
    check("mclr pc", imem_addr_o, 32'h0);
    rst_n = 1'b1;

    // End of memory: 0x3FC valid, 0x400 is a bubble with fetch fault despite aliasing.
    redirect_i        = 1'b1;
    redirect_target_i = 32'h3F8;
    step();
    redirect_i = 1'b0;
    step();
    check("end pc", imem_addr_o, 32'h3FC);
    check_ifid("end-1", 32'h3F8, 32'h3FC, word_at(8'd254), 1'b1);
    step();
    check("last pc", imem_addr_o, 32'h400);
    check_ifid("last", 32'h3FC, 32'h400, word_at(8'd255), 1'b1);
    check("last ffault", 32'(fetch_fault_o), 32'h0);
    step();
    check("oor pc", imem_addr_o, 32'h404);
    check_ifid("oor", 32'h400, 32'h404, Nop, 1'b0);
    check("oor ffault", 32'(fetch_fault_o), 32'h1);
    step();
    check("oor sticky", 32'(fetch_fault_o), 32'h1);
    check("oor valid", 32'(if_id_valid_o), 32'h0);

    // Reset together with redirect and stall discards both.
    rst_n             = 1'b0;
    stall_i           = 1'b1;
    redirect_i        = 1'b1;
    redirect_target_i = 32'h81;
    step();
    check("rst-redir pc", imem_addr_o, 32'h0);
    check_ifid("rst-redir", 32'h0, 32'h0, Nop, 1'b0);
    check("rst-redir ffault", 32'(fetch_fault_o), 32'h0);
    check("rst-redir mfault", 32'(misalign_fault_o), 32'h0);

    // Wrap from the top of the address space to zero.
    rst_n             = 1'b1;
    stall_i           = 1'b0;
    redirect_target_i = 32'hFFFF_FFFC;
    step();
    check("top pc", imem_addr_o, 32'hFFFF_FFFC);
    redirect_i = 1'b0;
    step();
    check("wrap pc", imem_addr_o, 32'h0);
    check_ifid("wrap", 32'hFFFF_FFFC, 32'h0, Nop, 1'b0);
    check("wrap ffault", 32'(fetch_fault_o), 32'h1);
    check("wrap mfault", 32'(misalign_fault_o), 32'h0);
    step();
    check("wrap next pc", imem_addr_o, 32'h4);
    check_ifid("wrap next", 32'h0, 32'h4, 32'h0050_0093, 1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
